// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: shares one register-file write port between the pipeline
// and a 2-entry completion buffer fed by a long-latency unit, with anti-starvation stall.
module wb_port_arbiter #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pipe_we,
    input  logic [4:0]       pipe_rd,
    input  logic [WIDTH-1:0] pipe_data,
    input  logic             lu_issue,
    input  logic [4:0]       lu_issue_rd,
    input  logic             lu_valid,
    input  logic [4:0]       lu_rd,
    input  logic [WIDTH-1:0] lu_data,
    output logic             lu_ready,
    output logic             rf_we,
    output logic [4:0]       rf_rd,
    output logic [WIDTH-1:0] rf_wd,
    output logic             wb_stall,
    output logic [31:0]      busy_vec
);

    localparam logic [3:0] WAIT_LAST = 4'(STARVE_LIMIT - 1);

    logic [4:0]       r_rd   [2];
    logic [WIDTH-1:0] r_data [2];
    logic             r_rptr;
    logic             r_wptr;
    logic [1:0]       r_cnt;
    logic [3:0]       r_wait;
    logic             r_stall;
    logic [31:0]      r_busy;

    logic        w_empty;
    logic        w_full;
    logic        w_enq;
    logic        w_pipe_ok;
    logic        w_gnt_buf;
    logic        w_gnt_pipe;
    logic        w_stall_d;
    logic [31:0] w_set;
    logic [31:0] w_clr;
    logic [31:0] w_busy_d;

    assign w_empty   = (r_cnt == 2'd0);
    assign w_full    = (r_cnt == 2'd2);
    assign lu_ready  = !w_full;
    // Results for x0 are acknowledged but never stored.
    assign w_enq     = lu_valid && !w_full && (lu_rd != 5'd0);
    assign w_pipe_ok = pipe_we && (pipe_rd != 5'd0);

    // A stall cycle reserves the port for the buffer head; the pipeline retries next cycle.
    assign w_gnt_buf  = !w_empty && (r_stall || !w_pipe_ok);
    assign w_gnt_pipe = w_pipe_ok && !r_stall;

    always_comb begin
        rf_we = 1'b0;
        rf_rd = 5'd0;
        rf_wd = '0;
        if (w_gnt_buf) begin
            rf_we = 1'b1;
            rf_rd = r_rd[r_rptr];
            rf_wd = r_data[r_rptr];
        end else if (w_gnt_pipe) begin
            rf_we = 1'b1;
            rf_rd = pipe_rd;
            rf_wd = pipe_data;
        end
    end

    assign w_stall_d = !w_empty && !w_gnt_buf && !r_stall && (r_wait == WAIT_LAST);

    always_comb begin
        w_set = 32'd0;
        w_clr = 32'd0;
        if (lu_issue && (lu_issue_rd != 5'd0)) begin
            w_set = 32'd1 << lu_issue_rd;
        end
        if (w_gnt_buf) begin
            w_clr = 32'd1 << r_rd[r_rptr];
        end
        // Set after clear so a same-cycle reissue keeps the bit.
        w_busy_d    = (r_busy & ~w_clr) | w_set;
        w_busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd[0]   <= 5'd0;
            r_rd[1]   <= 5'd0;
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_rptr    <= 1'b0;
            r_wptr    <= 1'b0;
            r_cnt     <= 2'd0;
            r_wait    <= 4'd0;
            r_stall   <= 1'b0;
            r_busy    <= 32'd0;
        end else begin
            if (w_enq) begin
                r_rd[r_wptr]   <= lu_rd;
                r_data[r_wptr] <= lu_data;
                r_wptr         <= !r_wptr;
            end
            if (w_gnt_buf) begin
                r_rptr <= !r_rptr;
            end
            r_cnt   <= r_cnt + 2'(w_enq) - 2'(w_gnt_buf);
            r_wait  <= (w_empty || w_gnt_buf) ? 4'd0 : r_wait + 4'd1;
            r_stall <= w_stall_d;
            r_busy  <= w_busy_d;
        end
    end

    assign wb_stall = r_stall;
    assign busy_vec = r_busy;

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: register data width.
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive blocked cycles before a forced long-unit write (range 1..15).
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 pipe_we  in  1  writeback-stage register write request (RegWriteW).
REQ-006 pipe_rd  in  5  writeback-stage destination register.
REQ-007 pipe_data  in  WIDTH  writeback-stage result (ResultW).
REQ-008 lu_issue  in  1  long-latency unit accepted an operation this cycle.
REQ-009 lu_issue_rd  in  5  destination of the issued long-latency operation.
REQ-010 lu_valid  in  1  long-latency unit presents a completed result.
REQ-011 lu_rd  in  5  destination of the completed result.
REQ-012 lu_data  in  WIDTH  completed result data.
REQ-013 lu_ready  out  1  arbiter accepts a completed result this cycle.
REQ-014 rf_we  out  1  register-file write enable.
REQ-015 rf_rd  out  5  register-file write address.
REQ-016 rf_wd  out  WIDTH  register-file write data.
REQ-017 wb_stall  out  1  pipeline must hold its writeback stage this cycle.
REQ-018 busy_vec  out  32  bit n set = register n has a pending long-latency write.

Function
REQ-019 Completion buffer: 2-entry FIFO of {rd, data}; lu_ready = not full, derived from registered state only.
REQ-020 Enqueue on lu_valid && lu_ready; entries with lu_rd==0 are accepted and discarded, not stored.
REQ-021 Full buffer: lu_ready=0 even if a dequeue occurs the same cycle; no enqueue/dequeue bypass.
REQ-022 An entry enqueued in cycle N is eligible for grant no earlier than cycle N+1.
REQ-023 Grant is combinational each cycle: if wb_stall=1, grant buffer head (if non-empty); else if pipe_we && pipe_rd!=0, grant pipeline; else if buffer non-empty, grant buffer head; else no grant.
REQ-024 Pipeline grant: rf_we=1, rf_rd=pipe_rd, rf_wd=pipe_data.
REQ-025 Buffer grant: rf_we=1, rf_rd/rf_wd from head; head dequeued at posedge.
REQ-026 No grant: rf_we=0, rf_rd=0, rf_wd=0.
REQ-027 pipe_we with pipe_rd==0: no write, slot free for the buffer.
REQ-028 When wb_stall=1 the pipeline inputs are not consumed; the pipeline re-presents them next cycle.
REQ-029 wait_cnt (4 bits): increments each cycle buffer non-empty and head not granted; clears on head grant or empty buffer.
REQ-030 wb_stall is registered: set for the next cycle when wait_cnt==STARVE_LIMIT-1 and head not granted this cycle; high exactly one cycle; never high on two consecutive cycles.
REQ-031 Scoreboard: lu_issue with lu_issue_rd!=0 sets busy_vec[lu_issue_rd] at next edge; a buffer grant clears busy_vec[rf_rd].
REQ-032 Same-cycle set and clear of the same bit: set wins.
REQ-033 busy_vec[0] is always 0; lu_issue to a register already busy is illegal (bench flags it).

Reset
REQ-034 rst_n low asynchronously: FIFO empty, wait_cnt=0, wb_stall=0, busy_vec=0; hence lu_ready=1, rf_we=0.
REQ-035 Reset mid-operation discards buffered results and pending scoreboard bits; no write issued during or on the first edge after reset release unless pipe_we is asserted.

Verification
REQ-036 Pipe-only: pipe_we=1, rd=5, data=0xA5 -> same cycle rf_we=1, rf_rd=5, rf_wd=0xA5; busy_vec unchanged.
REQ-037 Idle drain: lu_issue rd=7; 3 cycles later lu_valid rd=7 data=0x1234, pipe_we=0 -> next cycle rf_we=1, rf_rd=7, rf_wd=0x1234; busy_vec[7] 1 then 0.
REQ-038 Full buffer: two lu results accepted while pipe_we=1 every cycle -> lu_ready=0 on third; remains 0 until a dequeue edge.
REQ-039 Starvation: buffer non-empty, pipe_we=1 continuously, STARVE_LIMIT=4 -> wb_stall=1 exactly 4 cycles after enqueue-eligible; head written that cycle; pipe write retried next cycle.
REQ-040 Collision: lu_issue rd=9 same cycle as buffer grant of rd=9 -> busy_vec[9]=1 after edge.
REQ-041 Reset: assert rst_n=0 with 2 buffered entries and wb_stall=1 -> immediately lu_ready=1, wb_stall=0, busy_vec=0, no rf write after release.
